// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RV32I ALU between two requesters.
// Each requester uses a valid/ready request handshake. At most one requester
// is granted per cycle, with round-robin tie-breaking. The granted requester
// drives the ALU. Result, zero flag and an unsupported-op flag are captured into
// a per-requester response register that has its own valid/ready handshake.
// Operand/result width is 32 bits (word_t) and the op code is 4 bits (alu_op_t).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    // requester 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    // response 0
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    // response 1
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,
    // shared ALU
    output logic [3:0]  alu_op,
    output logic [31:0] alu_in_a,
    output logic [31:0] alu_in_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    // Idle op code: the ALU treats it as invalid and yields zero.
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    // Only AND/OR/ADD/SUB are supported; any other code flags an error.
    function automatic logic op_unsupported(input logic [3:0] op);
        logic bad;
        case (op)
            ALU_AND: bad = 1'b0;
            ALU_OR:  bad = 1'b0;
            ALU_ADD: bad = 1'b0;
            ALU_SUB: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // state
    logic        last_grant_q, last_grant_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [31:0] rsp0_result_q, rsp0_result_d;
    logic        rsp0_zero_q, rsp0_zero_d;
    logic        rsp0_err_q, rsp0_err_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp1_result_q, rsp1_result_d;
    logic        rsp1_zero_q, rsp1_zero_d;
    logic        rsp1_err_q, rsp1_err_d;

    // arbitration
    logic        elig0_s, elig1_s;
    logic        gnt0_s, gnt1_s;
    logic [3:0]  alu_op_s;
    logic [31:0] alu_in_a_s, alu_in_b_s;

    // Eligibility and round-robin grant; no grant can be issued while reset is held.
    always_comb begin
        elig0_s = req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1_s = req1_valid && (!rsp1_valid_q || rsp1_ready);
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (elig0_s && elig1_s) begin
            // last_grant_q == 1 means requester 1 went last, so requester 0 wins
            gnt0_s = last_grant_q;
            gnt1_s = !last_grant_q;
        end else begin
            gnt0_s = elig0_s;
            gnt1_s = elig1_s;
        end
    end

    // Route the granted requester onto the ALU; park it on the idle op otherwise.
    always_comb begin
        alu_op_s   = ALU_IDLE;
        alu_in_a_s = 32'h0000_0000;
        alu_in_b_s = 32'h0000_0000;
        if (gnt0_s) begin
            alu_op_s   = req0_op;
            alu_in_a_s = req0_a;
            alu_in_b_s = req0_b;
        end else if (gnt1_s) begin
            alu_op_s   = req1_op;
            alu_in_a_s = req1_a;
            alu_in_b_s = req1_b;
        end else begin
            alu_op_s   = ALU_IDLE;
            alu_in_a_s = 32'h0000_0000;
            alu_in_b_s = 32'h0000_0000;
        end
    end

    // Next state: capture on grant (drain+refill keeps valid high), release on consume.
    always_comb begin
        last_grant_d  = last_grant_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp0_err_d    = rsp0_err_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        rsp1_err_d    = rsp1_err_q;

        if (gnt0_s) begin
            last_grant_d = 1'b0;
        end else if (gnt1_s) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end

        if (gnt0_s) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
            rsp0_err_d    = op_unsupported(req0_op);
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end else begin
            rsp0_valid_d  = rsp0_valid_q;
        end

        if (gnt1_s) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
            rsp1_err_d    = op_unsupported(req1_op);
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end else begin
            rsp1_valid_d  = rsp1_valid_q;
        end
    end

    // State registers with synchronous active-low reset; reset drops pending responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 32'h0000_0000;
            rsp0_zero_q   <= 1'b0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 32'h0000_0000;
            rsp1_zero_q   <= 1'b0;
            rsp1_err_q    <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
            rsp1_err_q    <= rsp1_err_d;
        end
    end

    assign req0_ready  = gnt0_s;
    assign req1_ready  = gnt1_s;
    assign alu_op      = alu_op_s;
    assign alu_in_a    = alu_in_a_s;
    assign alu_in_b    = alu_in_b_s;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp0_err    = rsp0_err_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;
    assign rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the shared ALU, keeps a per-requester
// scoreboard of expected responses, and walks through the reset, handshake,
// round-robin, backpressure, error-flag and reset-recovery scenarios.
module tb_alu_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_a, alu_in_b, alu_result;
    logic        alu_zero;

    rsp_t q0[$];
    rsp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic g0, g1;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] env_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic rsp_t expect_rsp(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        rsp_t r;
        r.result = env_alu(op, a, b);
        r.zero   = (r.result == 32'h0);
        r.err    = !(op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB);
        return r;
    endfunction

    // Behavioural ALU seen by the arbiter
    always_comb begin
        alu_result = env_alu(alu_op, alu_in_a, alu_in_b);
        alu_zero   = (alu_result == 32'h0);
    end

    // Sample handshakes before the edge, push expectations, then step past the edge.
    task automatic cycle();
        g0 = req0_valid && req0_ready;
        g1 = req1_valid && req1_ready;
        if (g0) q0.push_back(expect_rsp(req0_op, req0_a, req0_b));
        if (g1) q1.push_back(expect_rsp(req1_op, req1_a, req1_b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h1; req0_b = 32'h2;
        req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 32'h4; req1_b = 32'h8;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cycle();
        cycle();
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({alu_op, alu_in_a, alu_in_b} !== {4'b1111, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL reset_alu got op=%h a=%h b=%h exp op=f a=0 b=0", alu_op, alu_in_a, alu_in_b);
        end
        n_checks++;
        if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== 70'h0) begin
            n_fail++; $display("FAIL reset_rsp got v0=%b r0=%h v1=%b r1=%h exp all 0", rsp0_valid, rsp0_result, rsp1_valid, rsp1_result);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
    endtask

    task automatic test_single_add();
        rsp_t e;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h5; req0_b = 32'h3;
        rsp0_ready = 1'b1;
        #2;
        n_checks++;
        if ({req0_ready, req1_ready, alu_op, alu_in_a, alu_in_b} !== {2'b10, OP_ADD, 32'h5, 32'h3}) begin
            n_fail++; $display("FAIL add_grant got rdy=%b%b op=%h a=%h b=%h exp rdy=10 op=2 a=5 b=3", req0_ready, req1_ready, alu_op, alu_in_a, alu_in_b);
        end
        cycle();
        req0_valid = 1'b0;
        n_checks++;
        if (q0.size() == 0) begin
            n_fail++; $display("FAIL add_sb got empty queue exp one entry");
        end else begin
            e = q0.pop_front();
            if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, e}) begin
                n_fail++; $display("FAIL add_rsp got v=%b r=%h z=%b e=%b exp v=1 r=%h z=%b e=%b", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, e.result, e.zero, e.err);
            end
        end
        n_checks++;
        if (rsp0_result !== 32'h8) begin
            n_fail++; $display("FAIL add_value got=%h exp=00000008", rsp0_result);
        end
        #2;
        cycle();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_release got=%b exp=0", rsp0_valid);
        end
    endtask

    task automatic test_contention();
        rsp_t e;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'h7;  req0_b = 32'h7;
        req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 32'hF0; req1_b = 32'h0F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_rdy;
            exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
            #2;
            n_checks++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant cycle %0d got=%b%b exp=%b", k, req0_ready, req1_ready, exp_rdy);
            end
            cycle();
            if (g0) begin
                n_checks++;
                e = q0.pop_front();
                if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, e}) begin
                    n_fail++; $display("FAIL rr_rsp0 got v=%b r=%h z=%b exp r=%h z=%b", rsp0_valid, rsp0_result, rsp0_zero, e.result, e.zero);
                end
            end
            if (g1) begin
                n_checks++;
                e = q1.pop_front();
                if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, e}) begin
                    n_fail++; $display("FAIL rr_rsp1 got v=%b r=%h z=%b exp r=%h z=%b", rsp1_valid, rsp1_result, rsp1_zero, e.result, e.zero);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if ({rsp0_result, rsp0_zero, rsp1_result} !== {32'h0, 1'b1, 32'hFF}) begin
            n_fail++; $display("FAIL rr_final got r0=%h z0=%b r1=%h exp r0=0 z0=1 r1=ff", rsp0_result, rsp0_zero, rsp1_result);
        end
    endtask

    task automatic test_backpressure();
        rsp_t e;
        rsp_t held;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h1;    req0_b = 32'h2;
        req1_valid = 1'b1; req1_op = OP_AND; req1_a = 32'hFF00; req1_b = 32'h0FF0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL bp_first got=%b%b exp=10", req0_ready, req1_ready);
        end
        cycle();
        e = q0.pop_front();
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_second got=%b%b exp=01", req0_ready, req1_ready);
        end
        cycle();
        held = q1.pop_front();
        n_checks++;
        if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, held}) begin
            n_fail++; $display("FAIL bp_rsp1 got v=%b r=%h exp v=1 r=%h", rsp1_valid, rsp1_result, held.result);
        end
        rsp1_ready = 1'b0;
        req1_op = OP_ADD; req1_a = 32'h100; req1_b = 32'h23;
        for (int k = 0; k < 3; k++) begin
            req0_a = 32'h10 + k;
            #2;
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b10) begin
                n_fail++; $display("FAIL bp_stall cycle %0d got=%b%b exp=10", k, req0_ready, req1_ready);
            end
            cycle();
            n_checks++;
            e = q0.pop_front();
            if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, e}) begin
                n_fail++; $display("FAIL bp_rsp0 cycle %0d got r=%h exp r=%h", k, rsp0_result, e.result);
            end
            n_checks++;
            if ({rsp1_valid, rsp1_result} !== {1'b1, held.result}) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got v=%b r=%h exp v=1 r=%h", k, rsp1_valid, rsp1_result, held.result);
            end
        end
        rsp1_ready = 1'b1;
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_regrant got=%b%b exp=01", req0_ready, req1_ready);
        end
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (q1.size() == 0) begin
            n_fail++; $display("FAIL bp_refill_sb got empty queue exp one entry");
        end else begin
            e = q1.pop_front();
            if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, e} || rsp1_result !== 32'h123) begin
                n_fail++; $display("FAIL bp_refill got v=%b r=%h exp v=1 r=%h", rsp1_valid, rsp1_result, e.result);
            end
        end
        #2;
        cycle();
    endtask

    task automatic test_invalid_op();
        rsp_t e;
        req1_valid = 1'b1; req1_op = 4'b0111; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1;
        rsp1_ready = 1'b1;
        #2;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL inv_grant got=%b exp=1", req1_ready);
        end
        cycle();
        req1_valid = 1'b0;
        n_checks++;
        e = q1.pop_front();
        if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, e} ||
            {rsp1_result, rsp1_zero, rsp1_err} !== {32'h0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL inv_rsp got r=%h z=%b e=%b exp r=0 z=1 e=1", rsp1_result, rsp1_zero, rsp1_err);
        end
        #2;
        cycle();
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        logic [3:0] ops [6];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, 4'b0111, 4'b1010};
        rsp0_ready = 1'b1;
        req0_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req0_op = ops[$urandom_range(0, 5)];
            req0_a  = $urandom;
            req0_b  = (k == 3) ? req0_a : $urandom;
            #2;
            n_checks++;
            if (req0_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_grant cycle %0d got=%b exp=1", k, req0_ready);
            end
            cycle();
            n_checks++;
            e = q0.pop_front();
            if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, e}) begin
                n_fail++; $display("FAIL b2b_rsp cycle %0d got v=%b r=%h z=%b e=%b exp r=%h z=%b e=%b", k, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, e.result, e.zero, e.err);
            end
        end
        req0_valid = 1'b0;
        #2;
        cycle();
    endtask

    task automatic test_reset_midop();
        rsp_t e;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h10; req0_b = 32'h20;
        rsp0_ready = 1'b0;
        #2;
        cycle();
        req0_valid = 1'b0;
        n_checks++;
        e = q0.pop_front();
        if ({rsp0_valid, rsp0_result} !== {1'b1, e.result}) begin
            n_fail++; $display("FAIL mid_pending got v=%b r=%h exp v=1 r=%h", rsp0_valid, rsp0_result, e.result);
        end
        rst_n = 1'b0;
        #2;
        cycle();
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        n_checks++;
        if ({rsp0_valid, rsp0_result} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL mid_discard got v=%b r=%h exp v=0 r=0", rsp0_valid, rsp0_result);
        end
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hF0F0; req0_b = 32'hFF00;
        req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 32'h1;    req1_b = 32'h2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL mid_first_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        e = q0.pop_front();
        if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, e}) begin
            n_fail++; $display("FAIL mid_rsp got r=%h exp r=%h", rsp0_result, e.result);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = OP_ADD; req0_a = 32'h0; req0_b = 32'h0;
        req1_valid = 1'b0; req1_op = OP_ADD; req1_a = 32'h0; req1_b = 32'h0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        g0 = 1'b0; g1 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_invalid_op();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational RV32I ALU between two requesters (e.g. the execute stage and the address/branch-compare path) using a valid/ready request/response handshake. Each cycle it grants at most one requester with a round-robin policy and drives the ALU operands and op. It captures the ALU result and zero flag into a per-requester response register. It sits between the requesters and one `alu` instance and is the only driver of the ALU inputs.

## Interface
Parameters:
- none; widths come from `riscv_32i_defs_pkg::word_t` (32 b) and `riscv_32i_control_pkg::alu_op_t` (4 b).

Ports:
- One clock; reset is synchronous and active-low.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester N has an operation.
- `req0_ready` / `req1_ready`  out  1  requester N is granted this cycle.
- `req0_op` / `req1_op`  in  alu_op_t  ALU operation.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  word_t  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  response register N holds a result.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer N accepts the response.
- `rsp0_result` / `rsp1_result`  out  word_t  captured ALU result.
- `rsp0_zero` / `rsp1_zero`  out  1  captured ALU zero flag.
- `rsp0_err` / `rsp1_err`  out  1  the op was not AND/OR/ADD/SUB.
- `alu_op`  out  alu_op_t  to the ALU.
- `alu_in_a`, `alu_in_b`  out  word_t  to the ALU.
- `alu_result`  in  word_t  from the ALU.
- `alu_zero`  in  1  from the ALU.

## Operation
- Slot free for requester N: `!rspN_valid || rspN_ready`.
- Eligible for requester N: `reqN_valid && slot free N`.
- Arbitration is combinational, one grant max:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not `last_grant`.
  - `reqN_ready` is 1 only for the granted requester. Valid-to-ready combinational paths are permitted.
- Round-robin state `last_grant` (1 b):
  - Updates to the granted index on every handshake.
  - Holds when there is no grant.
  - Resets to 1, so requester 0 wins the first contention.
- ALU drive:
  - With a grant: `alu_op`, `alu_in_a`, `alu_in_b` equal the granted requester's fields.
  - Without a grant: `alu_op = 4'b1111` (invalid, ALU yields 0), operands 0.
- Capture on handshake, at the clock edge:
  - `rspN_result <= alu_result`, `rspN_zero <= alu_zero`.
  - `rspN_err <= (op not in {0000, 0010, 0001, 0110})`.
  - `rspN_valid <= 1`.
- Release: when `rspN_valid && rspN_ready` and no new grant to N, `rspN_valid <= 0`. Data regs hold their last value.
- Drain plus refill in the same cycle: the new result overwrites and `rspN_valid` stays 1. No bubble.
- Requesters must hold `reqN_*` stable while valid and not ready. The arbiter does not latch requests.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - `rspN_valid` = 0, `rspN_result` = 0, `rspN_zero` = 0, `rspN_err` = 0, `last_grant` = 1.
  - `reqN_ready` is forced to 0 while `rst_n` is low.
- Latency: request handshake in cycle T gives `rspN_valid` = 1 with data in cycle T+1.
- Throughput: one op per cycle in total. Per requester, one op per cycle when its consumer holds `rspN_ready` = 1.
- Backpressure: while `rspN_valid` = 1 and `rspN_ready` = 0, requester N is not granted. The other requester may take every cycle.
- Starvation bound: an eligible requester is granted within 2 cycles.
- Reset mid-operation: pending responses are discarded. Requests in flight are not replayed.

## Test plan
- Reset then idle:
  - Hold `rst_n` = 0 for 2 cycles.
  - All `rsp*` outputs = 0, `alu_op` = 4'b1111, `alu_in_a` = `alu_in_b` = 0, `req*_ready` = 0.
- Single ADD on requester 0:
  - Stimulus: `req0` ADD, a = 32'h0000_0005, b = 32'h0000_0003, `rsp0_ready` = 1.
  - Same cycle: `req0_ready` = 1.
  - Next cycle: `rsp0_valid` = 1, `rsp0_result` = 32'h8, `rsp0_zero` = 0, `rsp0_err` = 0.
- Contention:
  - Stimulus: both valid for 4 cycles. `req0` SUB 7 - 7; `req1` OR 32'hF0 | 32'h0F.
  - Grants alternate 0, 1, 0, 1.
  - `rsp0_result` = 0 with `rsp0_zero` = 1; `rsp1_result` = 32'hFF.
- Backpressure:
  - Stimulus: `rsp1_ready` = 0 after the first result, both requesters valid.
  - `req1_ready` stays 0 and `req0` is granted every cycle.
  - `rsp1_result` holds its value until `rsp1_ready` = 1. The following cycle `req1` is granted again, with drain and refill and no bubble.
- Invalid op:
  - Stimulus: `req1_op` = 4'b0111, a = 32'hFFFF_FFFF, b = 1.
  - Next cycle: `rsp1_result` = 0, `rsp1_zero` = 1, `rsp1_err` = 1.
- Reset mid-operation:
  - Stimulus: `rsp0_valid` = 1 with `rsp0_ready` = 0, then pulse `rst_n` low for 1 cycle.
  - Next cycle: `rsp0_valid` = 0, `rsp0_result` = 0. With both requesters then contending, requester 0 is granted first.
